// File: rtl/dpm_port_arbiter.sv
// dpm_port_arbiter
// Shares the two ports of a dual_port_memory among NREQ requesters.
// Each cycle port A goes to the first valid requester at or after the
// round-robin pointer, and port B goes to the next valid requester after
// A's grant. If the two granted requests touch the same address and
// either one is a write, port B is withheld for that cycle. The registered
// read data from each port is routed back to the requester that issued
// the read, one cycle after acceptance.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/we/addr/wdata    per-requester request (packed buses)
//   req_ready                  combinational grant, one bit per requester
//   rsp_valid/rsp_data         one-cycle read response per requester
//   mem_addr_x/en_x/d_x        drive memory port x (en_x = write enable)
//   mem_q_x                    registered read data from memory port x
module dpm_port_arbiter #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 256,
  parameter  int NREQ  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_we,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [NREQ*WIDTH-1:0] rsp_data,
  output logic [AW-1:0]         mem_addr_a,
  output logic                  mem_en_a,
  output logic [WIDTH-1:0]      mem_d_a,
  input  logic [WIDTH-1:0]      mem_q_a,
  output logic [AW-1:0]         mem_addr_b,
  output logic                  mem_en_b,
  output logic [WIDTH-1:0]      mem_d_b,
  input  logic [WIDTH-1:0]      mem_q_b
);

  logic [AW-1:0]    w_addr  [NREQ];
  logic [WIDTH-1:0] w_wdata [NREQ];

  logic [IDW-1:0] r_rr_ptr;
  logic           r_pend_a, r_pend_b;
  logic [IDW-1:0] r_id_a, r_id_b;

  logic           w_gnt_a_vld, w_gnt_b_vld;
  logic [IDW-1:0] w_gnt_a, w_gnt_b;
  logic [IDW-1:0] w_rr_next;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_addr[gi]  = req_addr[gi*AW +: AW];
      assign w_wdata[gi] = req_wdata[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Grant selection. The B scan starts just after A's grant, so it can
  // never pick A's requester. The grants are suppressed while in reset.
  always_comb begin
    w_gnt_a_vld = 1'b0;
    w_gnt_a     = '0;
    w_gnt_b_vld = 1'b0;
    w_gnt_b     = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_gnt_a_vld && req_valid[(int'(r_rr_ptr) + k) % NREQ]) begin
        w_gnt_a_vld = 1'b1;
        w_gnt_a     = IDW'((int'(r_rr_ptr) + k) % NREQ);
      end
    end
    if (w_gnt_a_vld) begin
      for (int k = 1; k < NREQ; k++) begin
        if (!w_gnt_b_vld && req_valid[(int'(w_gnt_a) + k) % NREQ]) begin
          w_gnt_b_vld = 1'b1;
          w_gnt_b     = IDW'((int'(w_gnt_a) + k) % NREQ);
        end
      end
    end
    // Same-address hazard: withhold B. B's requester then sits right after
    // the new pointer, so it wins port A on the following cycle.
    if (w_gnt_b_vld && (w_addr[w_gnt_a] == w_addr[w_gnt_b]) &&
        (req_we[w_gnt_a] || req_we[w_gnt_b])) begin
      w_gnt_b_vld = 1'b0;
    end
    if (!rst_n) begin
      w_gnt_a_vld = 1'b0;
      w_gnt_b_vld = 1'b0;
    end
  end

  always_comb begin
    w_rr_next = r_rr_ptr;
    if (w_gnt_b_vld) begin
      w_rr_next = IDW'((int'(w_gnt_b) + 1) % NREQ);
    end else if (w_gnt_a_vld) begin
      w_rr_next = IDW'((int'(w_gnt_a) + 1) % NREQ);
    end
  end

  assign mem_en_a   = w_gnt_a_vld & req_we[w_gnt_a];
  assign mem_addr_a = w_gnt_a_vld ? w_addr[w_gnt_a]  : '0;
  assign mem_d_a    = w_gnt_a_vld ? w_wdata[w_gnt_a] : '0;
  assign mem_en_b   = w_gnt_b_vld & req_we[w_gnt_b];
  assign mem_addr_b = w_gnt_b_vld ? w_addr[w_gnt_b]  : '0;
  assign mem_d_b    = w_gnt_b_vld ? w_wdata[w_gnt_b] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_pend_a <= 1'b0;
      r_pend_b <= 1'b0;
      r_id_a   <= '0;
      r_id_b   <= '0;
    end else begin
      r_rr_ptr <= w_rr_next;
      r_pend_a <= w_gnt_a_vld & ~req_we[w_gnt_a];
      r_pend_b <= w_gnt_b_vld & ~req_we[w_gnt_b];
      if (w_gnt_a_vld) r_id_a <= w_gnt_a;
      if (w_gnt_b_vld) r_id_b <= w_gnt_b;
    end
  end

  // Per-requester grant and response routing. A and B never target the
  // same requester in one cycle, so the A-first priority is only a mux.
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_route
      logic w_hit_a, w_hit_b;
      assign req_ready[gi] = (w_gnt_a_vld && (w_gnt_a == IDW'(gi))) ||
                             (w_gnt_b_vld && (w_gnt_b == IDW'(gi)));
      assign w_hit_a = r_pend_a && (r_id_a == IDW'(gi));
      assign w_hit_b = r_pend_b && (r_id_b == IDW'(gi));
      assign rsp_valid[gi] = w_hit_a | w_hit_b;
      assign rsp_data[gi*WIDTH +: WIDTH] = w_hit_a ? mem_q_a :
                                           w_hit_b ? mem_q_b : '0;
    end
  endgenerate

endmodule

// File: doc/dpm_port_arbiter.md
Name: dpm_port_arbiter

Overview:
Round-robin arbiter that shares the two ports of `dual_port_memory` among NREQ independent requesters. Each cycle it grants up to two requests, one per memory port. It blocks same-address hazards between the ports. It routes the registered read data back to the requester that issued the read. It sits between client engines and a single `dual_port_memory` instance.

Parameters:
WIDTH, 8, data word width (matches memory WIDTH)
DEPTH, 256, memory words (matches memory DEPTH); AW = $clog2(DEPTH) derived locally
NREQ, 4, number of requesters, 2..8

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester request valid
req_we  input  NREQ  1 = write, 0 = read
req_addr  input  NREQ*AW  packed addresses; requester i at [i*AW +: AW]
req_wdata  input  NREQ*WIDTH  packed write data
req_ready  output  NREQ  request accepted this cycle (combinational grant)
rsp_valid  output  NREQ  read data valid, one-cycle pulse
rsp_data  output  NREQ*WIDTH  packed read data, meaningful only with rsp_valid
mem_addr_a  output  AW  to memory addr_a
mem_en_a  output  1  to memory en_a (write enable)
mem_d_a  output  WIDTH  to memory d_a
mem_q_a  input  WIDTH  from memory q_a
mem_addr_b  output  AW  to memory addr_b
mem_en_b  output  1  to memory en_b
mem_d_b  output  WIDTH  to memory d_b
mem_q_b  input  WIDTH  from memory q_b

Behaviour:
Interface:
- One clock `clk`; reset `rst_n` is asynchronous and active-low.

Handshake:
- A request transfers on a cycle where req_valid[i] && req_ready[i].
- While req_valid[i] is high and unaccepted, the requester holds req_we/addr/wdata stable.
- req_ready is combinational from req_valid, the addresses and rr_ptr.
- No response backpressure.

Arbitration, same cycle:
- Port A gets the first valid requester scanning cyclically from rr_ptr.
- Port B gets the next valid requester scanning cyclically from A's grant + 1, excluding A's grant.
- Hazard: if A and B addresses are equal and either is a write, B is not granted this cycle.
- At most one grant per requester per cycle.

Memory drive:
- Granted port: mem_addr_x = granted address; mem_en_x = granted req_we; mem_d_x = granted wdata.
- Ungranted port: mem_en_x = 0; addr/d are don't-care but driven to 0.

Pointer update (registered):
- Both ports granted (B = j): rr_ptr <= (j+1) mod NREQ.
- Only A granted (A = i): rr_ptr <= (i+1) mod NREQ.
- No grant: rr_ptr unchanged.

Read response:
- On a granted read, register pend_x <= 1 and id_x <= requester index; writes set pend_x <= 0.
- Next cycle: rsp_valid[id_x] = pend_x, rsp_data slot id_x = mem_q_x.
- Read latency is exactly 1 cycle after acceptance.
- A and B responses never target the same requester, since there is one grant per requester per cycle.
- A requester may issue back-to-back reads; each produces one pulse.

Write completion:
- A write completes on acceptance; no response.
- A read accepted the cycle after a write to the same address (either port) returns the new data.

Reset:
- rst_n low forces rr_ptr = 0, pend_a = pend_b = 0, id_a = id_b = 0.
- Consequently rsp_valid = 0 and rsp_data = 0.
- req_ready = 0, mem_en_a = mem_en_b = 0, mem_addr_* = 0, mem_d_* = 0 while in reset.
- In-flight read responses are dropped on reset.
- Operation resumes on the first clk edge after deassertion.

Boundaries:
- Single valid requester: granted on port A regardless of rr_ptr.
- NREQ valid with no hazards: 2 grants per cycle, each requester served within ceil(NREQ/2) cycles.
- A hazard-blocked requester is next in the pointer order, so it wins port A the following cycle (no starvation).
- rr_ptr wraps NREQ-1 -> 0.

Test Plan:
- Req0 writes addr 5 = 0xA5, then reads addr 5 -> req_ready[0] each cycle; rsp_valid[0] pulses 1 cycle after the read grant with rsp_data0 = 0xA5.
- All 4 requesters continuously reading addrs 10..13 -> grant pairs (0,1),(2,3),(0,1)...; each rsp pulse carries ram contents for its own address.
- rr_ptr = 0; req0 writes addr 7 = 0x3C while req1 reads addr 7 -> only req0 ready; next cycle req1 granted on port A; response = 0x3C.
- Req2 writes addr 1 = 0x11 and req3 writes addr 2 = 0x22 in the same cycle -> both ready, mem_en_a = mem_en_b = 1; later reads return 0x11 and 0x22.
- Req1 read granted, rst_n pulled low before the next edge -> rsp_valid = 0 immediately, no response after release; rr_ptr = 0, so req0 wins port A first.
- Only req3 valid with rr_ptr = 1, reading addr 255 -> granted on port A the same cycle; rr_ptr wraps to 0.
